rggen_indirect_access_master: RTL and testbench
===============================================

# rggen_indirect_access_master

Host-side initiator for indirect registers: turns one upstream command (index, write flag, data) into the two-phase bus sequence that an indirect register responder expects. It first writes the index to the index register, then reads or writes the shared data window. It sits between a CPU/test port and the register block's host bus. It can optionally cache the last index written so that repeated accesses to the same index skip the index phase.

## Interface
- ADDRESS_WIDTH, 16, bus address width
- DATA_WIDTH, 32, bus data width
- INDEX_WIDTH, 8, index width; must be ≤ DATA_WIDTH
- INDEX_ADDRESS, '0, byte address of the index register
- DATA_ADDRESS, 'h4, byte address of the indirect data window
- SKIP_REDUNDANT_INDEX, 1'b1, enables the index cache

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_cmd_valid  input  1  command request
- o_cmd_ready  output  1  command accept
- i_cmd_write  input  1  1 = write, 0 = read
- i_cmd_index  input  INDEX_WIDTH  target index
- i_cmd_data  input  DATA_WIDTH  write data
- o_rsp_valid  output  1  response available
- i_rsp_ready  input  1  response consumed
- o_rsp_data  output  DATA_WIDTH  read data (0 for writes)
- o_rsp_status  output  2  0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR
- o_bus_valid  output  1  bus request
- o_bus_address  output  ADDRESS_WIDTH  bus address
- o_bus_write  output  1  bus write
- o_bus_write_data  output  DATA_WIDTH  bus write data
- i_bus_ready  input  1  bus access complete
- i_bus_status  input  2  bus response status
- i_bus_read_data  input  DATA_WIDTH  bus read data

## Operation
- **States:** IDLE, INDEX, DATA, RESP.
- **IDLE**
  - o_cmd_ready = 1 when state is IDLE and rst is low.
  - On i_cmd_valid & o_cmd_ready, the block registers write flag, index and data.
  - Next state is DATA if SKIP_REDUNDANT_INDEX, the cache is valid and the cached index equals i_cmd_index; otherwise INDEX.
- **INDEX**
  - Drives o_bus_valid = 1, o_bus_address = INDEX_ADDRESS, o_bus_write = 1, and o_bus_write_data = index zero-extended to DATA_WIDTH.
  - On i_bus_ready with i_bus_status[1] = 0: the cache is loaded (valid, index) and the next state is DATA.
  - On i_bus_ready with i_bus_status[1] = 1: the cache is invalidated and the next state is RESP with status = i_bus_status and data = 0. The data phase is not issued.
- **DATA**
  - Drives o_bus_valid = 1, o_bus_address = DATA_ADDRESS, o_bus_write = the command's write flag, and o_bus_write_data = the command's data.
  - On i_bus_ready: status is captured from i_bus_status.
  - Data is captured from i_bus_read_data for reads; it is forced to 0 for writes.
  - Next state is RESP.
  - An error status in DATA does not invalidate the cache.
- **RESP**
  - o_rsp_valid = 1 with stable o_rsp_data and o_rsp_status.
  - On i_rsp_ready, the next state is IDLE.
- **Bus outputs:** all bus outputs are registered and held stable while o_bus_valid = 1 and i_bus_ready = 0.
- **Reset values:** while rst is high, and on the cycle after it:
  - state is IDLE; o_cmd_ready = 0 during rst.
  - o_bus_valid = 0, o_bus_write = 0, o_bus_address = 0, o_bus_write_data = 0.
  - o_rsp_valid = 0, o_rsp_data = 0, o_rsp_status = 0.
  - cache is invalid.
- **Reset mid-operation:** an in-flight transaction is abandoned without a response, and the cache is invalidated.

## Timing
- At most one command is outstanding. No command is accepted until the response handshake completes.
- With the command accepted at cycle 0 and zero-wait bus:
  - cycle 1: INDEX bus valid with ready.
  - cycle 2: DATA bus valid with ready.
  - cycle 3: o_rsp_valid.
- With a cache hit: DATA at cycle 1, o_rsp_valid at cycle 2.
- **Bus wait states:** each cycle with i_bus_ready = 0 extends its phase by one cycle.
- **Response handshake:** i_rsp_ready sampled high in the first RESP cycle gives o_cmd_ready = 1 in the next cycle. Throughput is therefore one command per 4 cycles (miss) or 3 cycles (hit).
- i_bus_ready is ignored when o_bus_valid = 0.
- i_rsp_ready is ignored outside RESP.

## Test plan
- **Read miss then hit.**
  - Read index 5 with bus read data 0xCAFE_0001.
  - Required bus sequence: write 0x0000_0005 to INDEX_ADDRESS, then read DATA_ADDRESS. Response is data 0xCAFE_0001, status 0, on cycle 3.
  - Repeat read index 5: only the DATA_ADDRESS read is issued; response on cycle 2.
- **Write with wait states.**
  - Write index 3, data 0x1234_5678, with i_bus_ready delayed 2 cycles per phase.
  - Bus outputs are held stable during waits. o_bus_write_data = 0x1234_5678 on the data phase. Response data 0, status 0.
- **Index-phase error.**
  - i_bus_status = 2 on the index write.
  - No data access is issued. Response status 2, data 0.
  - The next command to the same index re-issues the index write.
- **Response backpressure.**
  - Hold i_rsp_ready = 0 for 5 cycles.
  - o_rsp_valid, o_rsp_data and o_rsp_status stay stable; o_cmd_ready stays 0; no bus activity.
- **Reset mid-DATA.**
  - Assert rst while waiting on i_bus_ready.
  - The next cycle shows o_bus_valid = 0 and o_rsp_valid = 0.
  - A following command to the previous index issues the index phase again.
- **SKIP_REDUNDANT_INDEX = 0.**
  - Two reads to index 7: both issue the index write.

Source files
------------

// File: rtl/rggen_indirect_access_master.sv
// Indirect register initiator: turns one command into an index write followed by
// a data-window access, optionally skipping the index write when it is unchanged.
module rggen_indirect_access_master #(
    parameter int                       ADDRESS_WIDTH        = 16,
    parameter int                       DATA_WIDTH           = 32,
    parameter int                       INDEX_WIDTH          = 8,
    parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS        = '0,
    parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS         = 'h4,
    parameter bit                       SKIP_REDUNDANT_INDEX = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [INDEX_WIDTH-1:0]   i_cmd_index,
    input  logic [DATA_WIDTH-1:0]    i_cmd_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_data,
    output logic [1:0]               o_rsp_status,
    output logic                     o_bus_valid,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic                     o_bus_write,
    output logic [DATA_WIDTH-1:0]    o_bus_write_data,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [DATA_WIDTH-1:0]    i_bus_read_data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INDEX = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]             state;
    logic                   cmd_write;
    logic [INDEX_WIDTH-1:0] cmd_index;
    logic [DATA_WIDTH-1:0]  cmd_data;
    logic                   cache_valid;
    logic [INDEX_WIDTH-1:0] cache_index;
    logic [DATA_WIDTH-1:0]  index_ext;
    logic                   cache_hit;
    logic                   accept;

    always_comb begin
        index_ext                  = '0;
        index_ext[INDEX_WIDTH-1:0] = i_cmd_index;
    end

    assign cache_hit   = SKIP_REDUNDANT_INDEX && cache_valid && (cache_index == i_cmd_index);
    assign o_cmd_ready = (state == IDLE) && !rst;
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cmd_write        <= 1'b0;
            cmd_index        <= '0;
            cmd_data         <= '0;
            cache_valid      <= 1'b0;
            cache_index      <= '0;
            o_bus_valid      <= 1'b0;
            o_bus_address    <= '0;
            o_bus_write      <= 1'b0;
            o_bus_write_data <= '0;
            o_rsp_valid      <= 1'b0;
            o_rsp_data       <= '0;
            o_rsp_status     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_write   <= i_cmd_write;
                        cmd_index   <= i_cmd_index;
                        cmd_data    <= i_cmd_data;
                        o_bus_valid <= 1'b1;
                        if (cache_hit) begin
                            state            <= DATA;
                            o_bus_address    <= DATA_ADDRESS;
                            o_bus_write      <= i_cmd_write;
                            o_bus_write_data <= i_cmd_data;
                        end else begin
                            state            <= INDEX;
                            o_bus_address    <= INDEX_ADDRESS;
                            o_bus_write      <= 1'b1;
                            o_bus_write_data <= index_ext;
                        end
                    end
                end
                INDEX: begin
                    if (i_bus_ready) begin
                        if (!i_bus_status[1]) begin
                            state            <= DATA;
                            cache_valid      <= 1'b1;
                            cache_index      <= cmd_index;
                            o_bus_address    <= DATA_ADDRESS;
                            o_bus_write      <= cmd_write;
                            o_bus_write_data <= cmd_data;
                        end else begin
                            // A failed index write leaves the responder's index unknown.
                            state        <= RESP;
                            cache_valid  <= 1'b0;
                            o_bus_valid  <= 1'b0;
                            o_rsp_valid  <= 1'b1;
                            o_rsp_status <= i_bus_status;
                            o_rsp_data   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (i_bus_ready) begin
                        state        <= RESP;
                        o_bus_valid  <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_status <= i_bus_status;
                        o_rsp_data   <= cmd_write ? '0 : i_bus_read_data;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_indirect_access_master.sv
// Bench for rggen_indirect_access_master: directed vector table, randomized commands
// against a transaction-level model, and reset / no-cache sequences.
module tb_rggen_indirect_access_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid, cmd_write, rsp_ready, bus_ready;
    logic [7:0]  cmd_index;
    logic [31:0] cmd_data, bus_rdata;
    logic [1:0]  bus_status;

    logic        d0_cmd_ready, d0_rsp_valid, d0_bus_valid, d0_bus_write;
    logic [31:0] d0_rsp_data, d0_bus_wd;
    logic [1:0]  d0_rsp_status;
    logic [15:0] d0_bus_addr;
    logic        d1_cmd_ready, d1_rsp_valid, d1_bus_valid, d1_bus_write;
    logic [31:0] d1_rsp_data, d1_bus_wd;
    logic [1:0]  d1_rsp_status;
    logic [15:0] d1_bus_addr;

    logic        o_cmd_ready, o_rsp_valid, o_bus_valid, o_bus_write;
    logic [31:0] o_rsp_data, o_bus_wd;
    logic [1:0]  o_rsp_status;
    logic [15:0] o_bus_addr;

    int checks = 0;
    int errors = 0;
    logic        m_valid [2];
    logic [7:0]  m_idx [2];

    always #5 clk = ~clk;

    rggen_indirect_access_master #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .INDEX_WIDTH(8),
        .INDEX_ADDRESS(16'h0), .DATA_ADDRESS(16'h4), .SKIP_REDUNDANT_INDEX(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid && !sel), .o_cmd_ready(d0_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_index(cmd_index), .i_cmd_data(cmd_data),
        .o_rsp_valid(d0_rsp_valid), .i_rsp_ready(rsp_ready && !sel),
        .o_rsp_data(d0_rsp_data), .o_rsp_status(d0_rsp_status),
        .o_bus_valid(d0_bus_valid), .o_bus_address(d0_bus_addr),
        .o_bus_write(d0_bus_write), .o_bus_write_data(d0_bus_wd),
        .i_bus_ready(bus_ready && !sel), .i_bus_status(bus_status),
        .i_bus_read_data(bus_rdata)
    );

    rggen_indirect_access_master #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .INDEX_WIDTH(8),
        .INDEX_ADDRESS(16'h0), .DATA_ADDRESS(16'h4), .SKIP_REDUNDANT_INDEX(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid && sel), .o_cmd_ready(d1_cmd_ready),
        .i_cmd_write(cmd_write), .i_cmd_index(cmd_index), .i_cmd_data(cmd_data),
        .o_rsp_valid(d1_rsp_valid), .i_rsp_ready(rsp_ready && sel),
        .o_rsp_data(d1_rsp_data), .o_rsp_status(d1_rsp_status),
        .o_bus_valid(d1_bus_valid), .o_bus_address(d1_bus_addr),
        .o_bus_write(d1_bus_write), .o_bus_write_data(d1_bus_wd),
        .i_bus_ready(bus_ready && sel), .i_bus_status(bus_status),
        .i_bus_read_data(bus_rdata)
    );

    assign o_cmd_ready  = sel ? d1_cmd_ready  : d0_cmd_ready;
    assign o_rsp_valid  = sel ? d1_rsp_valid  : d0_rsp_valid;
    assign o_rsp_data   = sel ? d1_rsp_data   : d0_rsp_data;
    assign o_rsp_status = sel ? d1_rsp_status : d0_rsp_status;
    assign o_bus_valid  = sel ? d1_bus_valid  : d0_bus_valid;
    assign o_bus_addr   = sel ? d1_bus_addr   : d0_bus_addr;
    assign o_bus_write  = sel ? d1_bus_write  : d0_bus_write;
    assign o_bus_wd     = sel ? d1_bus_wd     : d0_bus_wd;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Transaction-level expectation: which phases appear, latency, response.
    task automatic model(input logic w, input logic [7:0] idx, input int iw, input logic [1:0] ist,
                         input int dw, input logic [1:0] dst, input logic [31:0] rd,
                         output int e_idx, output int e_data, output int e_lat,
                         output logic [31:0] e_rdata, output logic [1:0] e_st);
        int s;
        logic hit;
        s = sel ? 1 : 0;
        hit = !sel && m_valid[s] && (m_idx[s] == idx);
        e_idx = 0; e_data = 0; e_lat = 1; e_rdata = '0; e_st = '0;
        if (!hit) begin
            e_idx = 1;
            e_lat += iw + 1;
            if (ist[1]) begin
                m_valid[s] = 1'b0;
                e_st = ist;
            end else begin
                m_valid[s] = 1'b1;
                m_idx[s] = idx;
            end
        end
        if (hit || !ist[1]) begin
            e_data = 1;
            e_lat += dw + 1;
            e_st = dst;
            e_rdata = w ? 32'h0 : rd;
        end
    endtask

    task automatic run_cmd(input logic w, input logic [7:0] idx, input logic [31:0] data,
                           input int iw, input logic [1:0] ist, input int dw, input logic [1:0] dst,
                           input logic [31:0] rd, input int dly,
                           input int e_idx, input int e_data, input int e_lat,
                           input logic [31:0] e_rdata, input logic [1:0] e_st);
        int n_idx = 0, n_data = 0, lat = -1, guard = 0, wcnt = 0, hold = 0, cyc = 0, lim;
        logic held = 1'b0, done = 1'b0, is_idx;
        logic [63:0] p_bus, p_rsp;
        logic [31:0] idx_wd = '0, dat_wd = '0;
        logic dat_wr = 1'b0;
        while (!o_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_before_cmd", 64'(o_cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_index = idx; cmd_data = data;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0; rsp_ready = 1'b0; bus_ready = 1'b0;
            if (held)
                chk("bus_hold", {13'd0, o_bus_valid, o_bus_write, o_bus_addr, o_bus_wd}, p_bus);
            held = 1'b0;
            if (o_bus_valid) begin
                is_idx = (o_bus_addr == 16'h0);
                if (wcnt == 0) begin
                    if (is_idx) begin
                        n_idx++;
                        idx_wd = o_bus_wd;
                        chk("index_write_flag", 64'(o_bus_write), 64'd1);
                    end else begin
                        n_data++;
                        dat_wd = o_bus_wd;
                        dat_wr = o_bus_write;
                        chk("data_address", 64'(o_bus_addr), 64'h4);
                    end
                end
                lim = is_idx ? iw : dw;
                if (wcnt < lim) begin
                    wcnt++;
                    held = 1'b1;
                    p_bus = {13'd0, o_bus_valid, o_bus_write, o_bus_addr, o_bus_wd};
                end else begin
                    bus_ready = 1'b1;
                    bus_status = is_idx ? ist : dst;
                    bus_rdata = rd;
                    wcnt = 0;
                end
            end
            if (o_rsp_valid) begin
                if (lat < 0) begin
                    lat = cyc;
                    p_rsp = {30'd0, o_rsp_status, o_rsp_data};
                end else begin
                    chk("rsp_hold", {30'd0, o_rsp_status, o_rsp_data}, p_rsp);
                    chk("cmd_ready_in_resp", 64'(o_cmd_ready), 64'd0);
                    chk("bus_idle_in_resp", 64'(o_bus_valid), 64'd0);
                end
                if (hold >= dly) begin
                    rsp_ready = 1'b1;
                    done = 1'b1;
                end else begin
                    hold++;
                end
            end
        end
        chk("rsp_seen", 64'(done), 64'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("cmd_ready_after_rsp", 64'(o_cmd_ready), 64'd1);
        chk("rsp_valid_after_rsp", 64'(o_rsp_valid), 64'd0);
        chk("index_phases", 64'(n_idx), 64'(e_idx));
        chk("data_phases", 64'(n_data), 64'(e_data));
        chk("latency", 64'(lat), 64'(e_lat));
        chk("rsp_data", 64'(p_rsp[31:0]), 64'(e_rdata));
        chk("rsp_status", 64'(p_rsp[33:32]), 64'(e_st));
        if (n_idx > 0) chk("index_write_data", 64'(idx_wd), {56'd0, idx});
        if (n_data > 0) begin
            chk("data_write_flag", 64'(dat_wr), 64'(w));
            chk("data_write_data", 64'(dat_wd), 64'(data));
        end
    endtask

    typedef struct {
        logic w; logic [7:0] idx; logic [31:0] data;
        int iw; logic [1:0] ist; int dw; logic [1:0] dst; logic [31:0] rd; int dly;
        int e_idx; int e_data; int e_lat; logic [31:0] e_rdata; logic [1:0] e_st;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int ei, ed, el;
        logic [31:0] er;
        logic [1:0] es;
        logic [7:0] pool [4];
        logic w;
        logic [7:0] idx;
        logic [31:0] data, rd;
        logic [1:0] ist, dst;
        int iw, dw, dly, guard;

        tbl[0] = '{1'b0, 8'h05, 32'h0,         0, 2'd0, 0, 2'd0, 32'hCAFE_0001, 0, 1, 1, 3, 32'hCAFE_0001, 2'd0};
        tbl[1] = '{1'b0, 8'h05, 32'h0,         0, 2'd0, 0, 2'd0, 32'hCAFE_0002, 0, 0, 1, 2, 32'hCAFE_0002, 2'd0};
        tbl[2] = '{1'b1, 8'h03, 32'h1234_5678, 2, 2'd0, 2, 2'd0, 32'hFFFF_0000, 0, 1, 1, 7, 32'h0,         2'd0};
        tbl[3] = '{1'b0, 8'h03, 32'h0,         0, 2'd0, 0, 2'd1, 32'hA5A5_A5A5, 1, 0, 1, 2, 32'hA5A5_A5A5, 2'd1};
        tbl[4] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 0, 2'd2, 0, 2'd0, 32'h0,         0, 1, 0, 2, 32'h0,         2'd2};
        tbl[5] = '{1'b1, 8'h10, 32'h0BAD_F00D, 0, 2'd0, 0, 2'd3, 32'h0,         0, 1, 1, 3, 32'h0,         2'd3};
        tbl[6] = '{1'b0, 8'h10, 32'h0,         0, 2'd0, 0, 2'd0, 32'h1111_2222, 5, 0, 1, 2, 32'h1111_2222, 2'd0};
        tbl[7] = '{1'b0, 8'hFF, 32'h0,         1, 2'd3, 0, 2'd0, 32'h9999_9999, 0, 1, 0, 3, 32'h0,         2'd3};
        pool[0] = 8'h01; pool[1] = 8'h02; pool[2] = 8'h03; pool[3] = 8'h80;

        sel = 1'b0; rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_data = '0;
        rsp_ready = 1'b0; bus_ready = 1'b0; bus_status = '0; bus_rdata = '0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_idx[0] = '0; m_idx[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 64'(o_cmd_ready), 64'd0);
        chk("reset_bus_valid", 64'(o_bus_valid), 64'd0);
        chk("reset_bus_write", 64'(o_bus_write), 64'd0);
        chk("reset_bus_addr", 64'(o_bus_addr), 64'd0);
        chk("reset_bus_wd", 64'(o_bus_wd), 64'd0);
        chk("reset_rsp", {29'd0, o_rsp_valid, o_rsp_status, o_rsp_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("post_reset_bus_valid", 64'(o_bus_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].w, tbl[i].idx, tbl[i].iw, tbl[i].ist, tbl[i].dw, tbl[i].dst, tbl[i].rd,
                  ei, ed, el, er, es);
            run_cmd(tbl[i].w, tbl[i].idx, tbl[i].data, tbl[i].iw, tbl[i].ist, tbl[i].dw, tbl[i].dst,
                    tbl[i].rd, tbl[i].dly, tbl[i].e_idx, tbl[i].e_data, tbl[i].e_lat,
                    tbl[i].e_rdata, tbl[i].e_st);
        end

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            idx = pool[$urandom_range(0, 3)];
            data = $urandom;
            rd = $urandom;
            iw = int'($urandom_range(0, 2));
            dw = int'($urandom_range(0, 2));
            dly = int'($urandom_range(0, 2));
            ist = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            dst = 2'($urandom_range(0, 3));
            model(w, idx, iw, ist, dw, dst, rd, ei, ed, el, er, es);
            run_cmd(w, idx, data, iw, ist, dw, dst, rd, dly, ei, ed, el, er, es);
        end

        // Reset while the data phase is waiting on the bus.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_index = 8'h42; cmd_data = '0;
        guard = 0;
        while (rst == 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
            cmd_valid = 1'b0;
            bus_ready = 1'b0;
            if (o_bus_valid && o_bus_addr == 16'h0) begin
                bus_ready = 1'b1;
                bus_status = 2'd0;
            end else if (o_bus_valid && o_bus_addr == 16'h4) begin
                rst = 1'b1;
            end
        end
        chk("reached_data_phase", 64'(rst), 64'd1);
        @(negedge clk);
        chk("midreset_bus_valid", 64'(o_bus_valid), 64'd0);
        chk("midreset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("midreset_cmd_ready", 64'(o_cmd_ready), 64'd0);
        rst = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        @(negedge clk);
        chk("after_midreset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("after_midreset_cmd_ready", 64'(o_cmd_ready), 64'd1);
        model(1'b0, 8'h42, 0, 2'd0, 0, 2'd0, 32'h4242_0000, ei, ed, el, er, es);
        run_cmd(1'b0, 8'h42, 32'h0, 0, 2'd0, 0, 2'd0, 32'h4242_0000, 0, 1, 1, 3, 32'h4242_0000, 2'd0);

        // Index cache disabled: every command issues the index write.
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model(1'b0, 8'h07, 0, 2'd0, 0, 2'd0, 32'h7070_0000 + 32'(i), ei, ed, el, er, es);
            run_cmd(1'b0, 8'h07, 32'h0, 0, 2'd0, 0, 2'd0, 32'h7070_0000 + 32'(i), 0,
                    1, 1, 3, 32'h7070_0000 + 32'(i), 2'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
